// File: rtl/datapath.sv
// Single-cycle accumulator datapath: PC/IR fetch, 16x8 register file, ALU, ACC and z/c flags.
// Define REGFILE_RESET_EN to clear the register file on reset; otherwise it keeps its contents.
module datapath_alu (
  input  logic [3:0] sel,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] imm,
  output logic [7:0] res,
  output logic       cy
);
  logic [8:0] r;

  // Bit 8 of r is the carry for every operation, so each case places its carry there.
  always_comb begin
    r = {1'b0, a};
    case (sel)
      4'b1000: r = {1'b0, a} + {1'b0, b};
      4'b1100: r = {1'b0, a} - {1'b0, b};
      4'b0100: r = {1'b0, ~(a | b)};
      4'b0001: r = {a, 1'b0};
      4'b0011: r = {a[0], 1'b0, a[7:1]};
      4'b0010: r = {1'b0, imm};
      default: r = {1'b0, a};
    endcase
  end

  assign res = r[7:0];
  assign cy  = r[8];
endmodule

module datapath (
  input  logic       clk,
  input  logic       CLB,
  input  logic       LoadIR,
  input  logic       IncPC,
  input  logic       SelPC,
  input  logic       LoadPC,
  input  logic       LoadReg,
  input  logic       LoadAcc,
  input  logic [1:0] SelACC,
  input  logic [3:0] SelALU,
  input  logic [7:0] imem_data,
  output logic [7:0] imem_addr,
  output logic [3:0] op,
  output logic       z,
  output logic       c,
  output logic [7:0] acc
);
  logic [7:0]       pc, ir, acc_q;
  logic             z_q, c_q;
  logic [15:0][7:0] rf;
  logic [3:0]       rsel;
  logic [7:0]       imm, rdat, alu_res, acc_nxt;
  logic             alu_cy;

  assign rsel = ir[3:0];
  assign imm  = {4'h0, ir[3:0]};
  assign rdat = rf[rsel];

  datapath_alu u_alu (
    .sel (SelALU),
    .a   (acc_q),
    .b   (rdat),
    .imm (imm),
    .res (alu_res),
    .cy  (alu_cy)
  );

  always_comb begin
    acc_nxt = acc_q;
    case (SelACC)
      2'b00:   acc_nxt = imm;
      2'b01:   acc_nxt = rdat;
      2'b10:   acc_nxt = alu_res;
      default: acc_nxt = acc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!CLB) begin
      pc    <= 8'h00;
      ir    <= 8'h00;
      acc_q <= 8'h00;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      if (LoadPC)     pc <= SelPC ? rdat : imm;
      else if (IncPC) pc <= pc + 8'h01;
      if (LoadIR)  ir    <= imem_data;
      if (LoadAcc) acc_q <= acc_nxt;
      if (LoadAcc && SelACC == 2'b10) begin
        z_q <= (alu_res == 8'h00);
        c_q <= alu_cy;
      end
    end
  end

  // Register writes take the pre-edge ACC, so a same-cycle ACC load is not visible here.
`ifdef REGFILE_RESET_EN
  always_ff @(posedge clk) begin
    if (!CLB)         rf <= '0;
    else if (LoadReg) rf[rsel] <= acc_q;
  end
`else
  always_ff @(posedge clk) begin
    if (CLB && LoadReg) rf[rsel] <= acc_q;
  end
`endif

  assign imem_addr = pc;
  assign op        = ir[7:4];
  assign acc       = acc_q;
  assign z         = z_q;
  assign c         = c_q;
endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: a reference model checked every cycle plus hand-computed spot checks.
module tb_datapath;
  logic       clk = 1'b0;
  logic       CLB, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0] SelACC;
  logic [3:0] SelALU;
  logic [7:0] imem_data, imem_addr, acc;
  logic [3:0] op;
  logic       z, c;

  typedef struct packed {
    logic       clb, ldir, inc, selpc, ldpc, ldreg, ldacc;
    logic [1:0] selacc;
    logic [3:0] selalu;
    logic [7:0] imem;
  } ctl_t;

  int   n_tests = 0, n_fail = 0;
  bit   chk_en = 0;
  int   m_pc, m_ir, m_acc, m_z, m_c;
  int   m_rf [16];

  datapath dut (
    .clk(clk), .CLB(CLB), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
    .LoadPC(LoadPC), .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelACC(SelACC),
    .SelALU(SelALU), .imem_data(imem_data), .imem_addr(imem_addr), .op(op),
    .z(z), .c(c), .acc(acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural state.
  task automatic model_step(input ctl_t t);
    int a, b, imm, res, cy, rs;
    if (!t.clb) begin
      m_pc = 0; m_ir = 0; m_acc = 0; m_z = 0; m_c = 0;
`ifdef REGFILE_RESET_EN
      for (int i = 0; i < 16; i++) m_rf[i] = 0;
`endif
      return;
    end
    rs = m_ir % 16; imm = rs; a = m_acc; b = m_rf[rs];
    cy = 0;
    case (t.selalu)
      4'b1000: begin res = a + b; cy = (res > 255); end
      4'b1100: begin res = a - b; cy = (a < b); end
      4'b0100: res = 255 - (a | b);
      4'b0001: begin res = a * 2; cy = (a >= 128); end
      4'b0011: begin res = a / 2; cy = a % 2; end
      4'b0010: res = imm;
      default: res = a;
    endcase
    res = (res + 512) % 256;
    if (t.ldacc) begin
      case (t.selacc)
        2'b00: m_acc = imm;
        2'b01: m_acc = b;
        2'b10: begin m_acc = res; m_z = (res == 0); m_c = cy; end
        default: ;
      endcase
    end
    if (t.ldreg) m_rf[rs] = a;
    if (t.ldpc) m_pc = t.selpc ? b : imm;
    else if (t.inc) m_pc = (m_pc + 1) % 256;
    if (t.ldir) m_ir = t.imem;
  endtask

  task automatic step(input ctl_t t);
    @(negedge clk);
    CLB = t.clb; LoadIR = t.ldir; IncPC = t.inc; SelPC = t.selpc; LoadPC = t.ldpc;
    LoadReg = t.ldreg; LoadAcc = t.ldacc; SelACC = t.selacc; SelALU = t.selalu;
    imem_data = t.imem;
    @(posedge clk);
    model_step(t);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_pc",  imem_addr,       8'(m_pc));
      chk("cyc_op",  {4'h0, op},      8'(m_ir / 16));
      chk("cyc_acc", acc,             8'(m_acc));
      chk("cyc_z",   {7'h0, z},       8'(m_z));
      chk("cyc_c",   {7'h0, c},       8'(m_c));
    end
  end

  function automatic ctl_t nop();
    ctl_t t = '0;
    t.clb = 1'b1;
    return t;
  endfunction

  task automatic ld_ir(input logic [7:0] v);
    ctl_t t = nop(); t.ldir = 1; t.imem = v; step(t);
  endtask
  task automatic acc_src(input logic [1:0] s);
    ctl_t t = nop(); t.ldacc = 1; t.selacc = s; step(t);
  endtask
  task automatic alu(input logic [3:0] f);
    ctl_t t = nop(); t.ldacc = 1; t.selacc = 2'b10; t.selalu = f; step(t);
  endtask
  task automatic ld_imm(input logic [3:0] n);
    ld_ir({4'hD, n}); acc_src(2'b00);
  endtask
  task automatic store(input logic [3:0] idx);
    ctl_t t = nop(); ld_ir({4'h0, idx}); t.ldreg = 1; step(t);
  endtask
  // Builds any byte in ACC: low nibble parked in reg 15, high nibble shifted up, then added.
  task automatic set_acc(input logic [7:0] v);
    ld_imm(v[3:0]); store(4'hF); ld_imm(v[7:4]);
    for (int i = 0; i < 4; i++) alu(4'b0001);
    ld_ir(8'h0F); alu(4'b1000);
  endtask
  task automatic set_reg(input logic [3:0] idx, input logic [7:0] v);
    set_acc(v); store(idx);
  endtask

  initial begin
    ctl_t t;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ctl_t t;
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
    t = '1; t.clb = 0; t.imem = 8'hA7;
    step(t); step(t);
    chk("rst_pc", imem_addr, 8'h00); chk("rst_op", {4'h0, op}, 8'h00);
    chk("rst_acc", acc, 8'h00); chk("rst_zc", {6'h0, z, c}, 8'h00);
    chk_en = 1;
`ifdef REGFILE_RESET_EN
    for (int i = 0; i < 16; i++) begin
      ld_ir(8'(i)); acc_src(2'b01); chk("rst_rf", acc, 8'h00);
    end
`endif
    // LDIM then ADD with overflow to zero
    ld_ir(8'hD5); acc_src(2'b00);
    chk("ldim_acc", acc, 8'h05); chk("ldim_zc", {6'h0, z, c}, 8'h00);
    set_reg(4'd1, 8'h01); set_acc(8'hFF); ld_ir(8'h81); alu(4'b1000);
    chk("add_acc", acc, 8'h00); chk("add_zc", {6'h0, z, c}, 8'h03);
    // SUB borrow, SHL, SHR
    set_reg(4'd2, 8'h05); set_acc(8'h03); ld_ir(8'h02); alu(4'b1100);
    chk("sub_acc", acc, 8'hFE); chk("sub_zc", {6'h0, z, c}, 8'h01);
    set_acc(8'h81); alu(4'b0001);
    chk("shl_acc", acc, 8'h02); chk("shl_zc", {6'h0, z, c}, 8'h01);
    set_acc(8'h01); alu(4'b0011);
    chk("shr_acc", acc, 8'h00); chk("shr_zc", {6'h0, z, c}, 8'h03);
    // NOR, pass imm, undefined code passes a, hold
    set_reg(4'd6, 8'h0F); set_acc(8'h30); ld_ir(8'h06); alu(4'b0100);
    chk("nor_acc", acc, 8'hC0); chk("nor_zc", {6'h0, z, c}, 8'h00);
    ld_ir(8'h09); alu(4'b0010); chk("imm_acc", acc, 8'h09);
    alu(4'b0111); chk("dflt_acc", acc, 8'h09);
    acc_src(2'b11); chk("hold_acc", acc, 8'h09);
    // PC control
    set_reg(4'd4, 8'hFF); ld_ir(8'h04);
    t = nop(); t.ldpc = 1; t.selpc = 1; step(t); chk("pc_ld_ff", imem_addr, 8'hFF);
    t = nop(); t.inc = 1; step(t); chk("pc_wrap", imem_addr, 8'h00);
    set_reg(4'd5, 8'h40); ld_ir(8'h05);
    t = nop(); t.ldpc = 1; t.inc = 1; t.selpc = 1; step(t); chk("pc_prio", imem_addr, 8'h40);
    ld_ir(8'h07);
    t = nop(); t.ldpc = 1; step(t); chk("pc_imm", imem_addr, 8'h07);
    // Simultaneous reg write and ACC load
    set_acc(8'h11); ld_ir(8'h43);
    t = nop(); t.ldreg = 1; t.ldacc = 1; step(t); chk("sim_acc", acc, 8'h03);
    acc_src(2'b01); chk("sim_reg3", acc, 8'h11);
    // Fetch
    t = nop(); t.ldir = 1; t.inc = 1; t.imem = 8'hB2; step(t);
    chk("fetch_op", {4'h0, op}, 8'h0B); chk("fetch_pc", imem_addr, 8'h08);
    // Reset mid-run with controls active, then a normal first cycle
    t = '1; t.clb = 0; t.imem = 8'hFF; step(t);
    chk("rst2_acc", acc, 8'h00); chk("rst2_pc", imem_addr, 8'h00);
    t = nop(); t.ldir = 1; t.inc = 1; t.imem = 8'h35; step(t);
    chk("post_op", {4'h0, op}, 8'h03); chk("post_pc", imem_addr, 8'h01);
    ld_ir(8'h03); acc_src(2'b01);
`ifdef REGFILE_RESET_EN
    chk("rf_after_rst", acc, 8'h00);
`else
    chk("rf_after_rst", acc, 8'h11);
`endif
    @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  single clock; all state updates on its rising edge.
- CLB  in  1  synchronous, active-low reset.
- LoadIR  in  1  load IR from imem_data.
- IncPC  in  1  PC increment.
- SelPC  in  1  jump source: 0 = immediate, 1 = register.
- LoadPC  in  1  load PC from the SelPC source.
- LoadReg  in  1  write ACC into reg[IR[3:0]].
- LoadAcc  in  1  load ACC from the SelACC source.
- SelACC  in  2  ACC source: 00 = immediate, 01 = register, 10 = ALU result, 11 = hold.
- SelALU  in  4  ALU operation code.
- imem_data  in  8  instruction byte at imem_addr (combinational read).
- imem_addr  out  8  equals PC.
- op  out  4  equals IR[7:4].
- z  out  1  registered zero flag.
- c  out  1  registered carry flag.
- acc  out  8  current ACC value.
REQ-002 Reset SHALL be synchronous and active-low on CLB, sampled on the rising edge of clk, which is the only clock.

Function
REQ-003 imm SHALL be IR[3:0] zero-extended to 8 bits; rsel SHALL be IR[3:0]; regfile SHALL be 16 x 8 bits with a combinational read of reg[rsel].
REQ-004 The ALU SHALL compute on ACC (a) and reg[rsel] (b), with 9-bit internal result r, by SelALU:
- 1000: a+b, carry = r[8].
- 1100: a-b, c = borrow (1 when a<b).
- 0100: ~(a|b), c = 0.
- 0001: a<<1, c = a[7].
- 0011: a>>1 logical, c = a[0].
- 0010: pass imm, c = 0.
- any other code: pass a, c = 0.
REQ-005 When LoadAcc=1, ACC SHALL take imm, reg[rsel], the ALU result[7:0] or its own value, per SelACC 00/01/10/11.
REQ-006 z and c SHALL update only when LoadAcc=1 and SelACC=10: z = (result[7:0]==0), c per REQ-004; otherwise they hold.
REQ-007 LoadIR=1 SHALL load IR with imem_data in the same edge in which PC updates.
REQ-008 PC priority SHALL be: LoadPC=1 loads imm (SelPC=0) or reg[rsel] (SelPC=1); else IncPC=1 sets PC+1; else PC holds.
REQ-009 PC increment SHALL wrap from 8'hFF to 8'h00 without any flag.
REQ-010 LoadReg=1 SHALL write the pre-edge ACC into reg[rsel]; when LoadReg and LoadAcc are both 1, the register receives the old ACC.
REQ-011 All operand reads (IR, ACC, regfile) SHALL use pre-edge values, giving single-cycle execute with no bypassing.
REQ-012 op, imem_addr and acc SHALL be driven directly from registers, with no combinational path from control inputs.

Reset
REQ-013 CLB=0 at a clock edge SHALL set PC=0, IR=0 (NOP, so op=0000), ACC=0, z=0 and c=0, overriding all control inputs in that cycle.
REQ-014 Reset asserted in any cycle SHALL abort any in-flight update; the first edge with CLB=1 SHALL behave as a normal cycle.

Configuration
REQ-015 Macro REGFILE_RESET_EN:
- Defined: all 16 registers SHALL clear to 0 under REQ-013.
- Undefined: the regfile SHALL be unaffected by reset and retain its contents.

Verification
REQ-016 Reset: hold CLB=0 for 2 cycles with all controls at 1 -> PC=0, op=0, acc=0, z=0, c=0; with REGFILE_RESET_EN, every reg reads 0.
REQ-017 LDIM then ADD: IR=8'hD5, SelACC=00, LoadAcc=1 -> acc=8'h05, flags unchanged; then ACC=8'hFF, reg[1]=8'h01, SelALU=1000, SelACC=10 -> acc=8'h00, z=1, c=1.
REQ-018 SUB borrow and shifts: ACC=8'h03, reg[2]=8'h05, SUB -> acc=8'hFE, c=1, z=0; ACC=8'h81 with SHL -> acc=8'h02, c=1; ACC=8'h01 with SHR -> acc=8'h00, z=1, c=1.
REQ-019 PC control: PC=8'hFF with IncPC -> PC=8'h00; LoadPC=1, IncPC=1, SelPC=1, reg[rsel]=8'h40 -> PC=8'h40; SelPC=0, IR[3:0]=4'h7 -> PC=8'h07.
REQ-020 Simultaneous writes: ACC=8'h11, LoadReg=1, LoadAcc=1, SelACC=00, IR=8'h43 -> reg[3]=8'h11, acc=8'h03.
REQ-021 Fetch: imem_data=8'hB2 with LoadIR=1, IncPC=1 -> op=4'hB next cycle, imem_addr incremented by 1.
